mc_maindec: RTL and testbench

MC_MAINDEC -- requirements
Module: mc_maindec

---
 rtl/mc_pkg.sv | 63 ++++++
 rtl/mc_ctrl_rom.sv | 74 +++++++
 rtl/mc_maindec.sv | 90 +++++++++
 tb/tb_mc_maindec.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle main decoder: FSM states, opcodes,
// ALU operation classes, datapath select values and the packed control word.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Everything a state drives, before the branch/zero and reset gating
    typedef struct packed {
        logic       iord;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSrc;
        logic       irWrite;
        logic       memWrite;
        logic       regWrite;
        logic       regDst;
        logic       memToReg;
        logic       pcWrite;
        logic       branch;
        logic       done;
    } ctrl_t;

    // True for the six opcodes the decoder knows how to sequence
    function automatic logic isLegalOp(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_ctrl_rom.sv
// Combinational state-to-control-word table for the multicycle decoder.
// Any encoding outside the twelve real states yields an all-zero word.
module mc_ctrl_rom
    import mc_pkg::*;
(
    input  state_t state_i,
    output ctrl_t  ctrl_o
);

    // Start from an all-zero word so unlisted signals stay low in every state
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            FETCH: begin
                ctrl_o.aluSrcB = SRCB_FOUR;
                ctrl_o.aluOp   = ALUOP_ADD;
                ctrl_o.pcSrc   = PCSRC_ALU;
                ctrl_o.irWrite = 1'b1;
                ctrl_o.pcWrite = 1'b1;
            end
            DECODE: begin
                ctrl_o.aluSrcB = SRCB_IMMSH;
                ctrl_o.aluOp   = ALUOP_ADD;
            end
            MEMADR, ADDIEX: begin
                ctrl_o.aluSrcA = 1'b1;
                ctrl_o.aluSrcB = SRCB_IMM;
                ctrl_o.aluOp   = ALUOP_ADD;
            end
            MEMRD: begin
                ctrl_o.iord = 1'b1;
            end
            MEMWB: begin
                ctrl_o.memToReg = 1'b1;
                ctrl_o.regWrite = 1'b1;
                ctrl_o.done     = 1'b1;
            end
            MEMWR: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.memWrite = 1'b1;
                ctrl_o.done     = 1'b1;
            end
            RTYPEEX: begin
                ctrl_o.aluSrcA = 1'b1;
                ctrl_o.aluSrcB = SRCB_REG;
                ctrl_o.aluOp   = ALUOP_FUNCT;
            end
            RTYPEWB: begin
                ctrl_o.regDst   = 1'b1;
                ctrl_o.regWrite = 1'b1;
                ctrl_o.done     = 1'b1;
            end
            BEQEX: begin
                ctrl_o.aluSrcA = 1'b1;
                ctrl_o.aluSrcB = SRCB_REG;
                ctrl_o.aluOp   = ALUOP_SUB;
                ctrl_o.pcSrc   = PCSRC_ALUOUT;
                ctrl_o.branch  = 1'b1;
                ctrl_o.done    = 1'b1;
            end
            ADDIWB: begin
                ctrl_o.regWrite = 1'b1;
                ctrl_o.done     = 1'b1;
            end
            JEX: begin
                ctrl_o.pcSrc   = PCSRC_JUMP;
                ctrl_o.pcWrite = 1'b1;
                ctrl_o.done    = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_maindec.sv
// Multicycle main decoder: state register, next-state logic and the gating
// of pc_en / illegal_op / write enables around the control ROM.
module mc_maindec
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    output logic [1:0] alu_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       iord,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       illegal_op,
    output logic       instr_done,
    output logic [3:0] state_o
);

    state_t state_q;
    state_t state_d;
    state_t romState;
    ctrl_t  ctrl;

    // Sequence each instruction class; unknown opcodes and stray encodings return to FETCH
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                if (op == OP_LW || op == OP_SW) state_d = MEMADR;
                else if (op == OP_RTYPE)        state_d = RTYPEEX;
                else if (op == OP_BEQ)          state_d = BEQEX;
                else if (op == OP_ADDI)         state_d = ADDIEX;
                else if (op == OP_J)            state_d = JEX;
                else                            state_d = FETCH;
            end
            MEMADR: begin
                if (op == OP_LW)      state_d = MEMRD;
                else if (op == OP_SW) state_d = MEMWR;
                else                  state_d = FETCH;
            end
            MEMRD:   state_d = MEMWB;
            RTYPEEX: state_d = RTYPEWB;
            ADDIEX:  state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // State register; reset wins from any state, including mid-instruction
    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // While in reset the datapath sees FETCH selects so it settles predictably
    always_comb begin
        romState = reset ? FETCH : state_q;
    end

    mc_ctrl_rom u_rom (
        .state_i (romState),
        .ctrl_o  (ctrl)
    );

    // Selects come straight from the ROM; anything that writes state is held off during reset
    always_comb begin
        alu_op     = ctrl.aluOp;
        alu_src_a  = ctrl.aluSrcA;
        alu_src_b  = ctrl.aluSrcB;
        iord       = ctrl.iord;
        reg_dst    = ctrl.regDst;
        mem_to_reg = ctrl.memToReg;
        pc_src     = ctrl.pcSrc;
        instr_done = ctrl.done;
        ir_write   = ctrl.irWrite  & ~reset;
        mem_write  = ctrl.memWrite & ~reset;
        reg_write  = ctrl.regWrite & ~reset;
        pc_en      = (ctrl.pcWrite | (ctrl.branch & zero)) & ~reset;
        illegal_op = ~reset && (state_q == DECODE) && !isLegalOp(op);
        state_o    = state_q;
    end

endmodule

// File: tb/tb_mc_maindec.sv
// Scoreboard bench for mc_maindec: a driver walks whole instructions and
// queues the expected per-cycle outputs, a monitor compares every cycle.
module tb_mc_maindec;
    import mc_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       iord, ir_write, mem_write, reg_write, reg_dst, mem_to_reg;
    logic [1:0] pc_src;
    logic       pc_en, illegal_op, instr_done;
    logic [3:0] state_o;

    typedef struct packed {
        logic [3:0] state;
        logic [1:0] aluOp;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic       iord;
        logic       irWrite;
        logic       memWrite;
        logic       regWrite;
        logic       regDst;
        logic       memToReg;
        logic [1:0] pcSrc;
        logic       pcEn;
        logic       illegalOp;
        logic       instrDone;
    } obs_t;

    obs_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    mc_maindec dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .iord       (iord),
        .ir_write   (ir_write),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .pc_src     (pc_src),
        .pc_en      (pc_en),
        .illegal_op (illegal_op),
        .instr_done (instr_done),
        .state_o    (state_o)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    function automatic logic knownOp(input logic [5:0] o);
        return o inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    // Reference outputs for one cycle, written from the per-state signal lists
    function automatic obs_t modelOut(input state_t s, input logic r, input logic [5:0] o, input logic z);
        obs_t e;
        state_t view;
        e = '0;
        e.state = s;
        view = r ? FETCH : s;
        case (view)
            FETCH:   begin e.aluSrcB = 2'b01; e.irWrite = 1'b1; e.pcEn = 1'b1; end
            DECODE:  begin e.aluSrcB = 2'b11; e.illegalOp = !knownOp(o); end
            MEMADR, ADDIEX: begin e.aluSrcA = 1'b1; e.aluSrcB = 2'b10; end
            MEMRD:   e.iord = 1'b1;
            MEMWR:   begin e.iord = 1'b1; e.memWrite = 1'b1; e.instrDone = 1'b1; end
            MEMWB:   begin e.memToReg = 1'b1; e.regWrite = 1'b1; e.instrDone = 1'b1; end
            RTYPEEX: begin e.aluSrcA = 1'b1; e.aluOp = 2'b10; end
            RTYPEWB: begin e.regDst = 1'b1; e.regWrite = 1'b1; e.instrDone = 1'b1; end
            BEQEX:   begin e.aluSrcA = 1'b1; e.aluOp = 2'b01; e.pcSrc = 2'b01; e.pcEn = z; e.instrDone = 1'b1; end
            ADDIWB:  begin e.regWrite = 1'b1; e.instrDone = 1'b1; end
            JEX:     begin e.pcSrc = 2'b10; e.pcEn = 1'b1; e.instrDone = 1'b1; end
            default: e = e;
        endcase
        if (r) begin
            e.pcEn = 1'b0; e.irWrite = 1'b0; e.memWrite = 1'b0; e.regWrite = 1'b0;
        end
        return e;
    endfunction

    // Drive one cycle's inputs just after the edge and queue what the DUT should show
    task automatic applyStimulus(input logic r, input logic [5:0] o, input logic z, input state_t s);
        @(posedge clk);
        #1;
        reset = r;
        op    = o;
        zero  = z;
        expQ.push_back(modelOut(s, r, o, z));
    endtask

    // One whole instruction; abortAt >= 0 asserts reset in that step and stops there.
    // zMode < 0 picks zero randomly each cycle, otherwise holds it at zMode.
    task automatic runInstr(input logic [5:0] o, input int abortAt, input int zMode);
        state_t seq[$];
        logic z;
        seq = '{FETCH, DECODE};
        case (o)
            6'b100011: seq = '{FETCH, DECODE, MEMADR, MEMRD, MEMWB};
            6'b101011: seq = '{FETCH, DECODE, MEMADR, MEMWR};
            6'b000000: seq = '{FETCH, DECODE, RTYPEEX, RTYPEWB};
            6'b001000: seq = '{FETCH, DECODE, ADDIEX, ADDIWB};
            6'b000100: seq = '{FETCH, DECODE, BEQEX};
            6'b000010: seq = '{FETCH, DECODE, JEX};
            default:   seq = '{FETCH, DECODE};
        endcase
        for (int i = 0; i < seq.size(); i++) begin
            z = (zMode < 0) ? 1'($urandom_range(0, 1)) : 1'(zMode);
            applyStimulus(i == abortAt, o, z, seq[i]);
            if (i == abortAt) break;
        end
    endtask

    // Compare one queued expectation against the live outputs
    task automatic checkOutput(input obs_t e);
        obs_t a;
        a = {state_o, alu_op, alu_src_a, alu_src_b, iord, ir_write, mem_write,
             reg_write, reg_dst, mem_to_reg, pc_src, pc_en, illegal_op, instr_done};
        checks++;
        if (a !== e) begin
            errors++;
            $display("[TB] FAIL cycle%0d outputs: actual=%b required=%b (state,aluop,srca,srcb,iord,irw,memw,regw,regdst,m2r,pcsrc,pcen,ill,done)",
                     cycle, a, e);
        end
    endtask

    // Monitor: on every falling edge take the oldest expectation, if any, and check it
    always @(negedge clk) begin
        cycle++;
        if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end

    // Stimulus: directed scenarios first, then random instructions with occasional resets
    initial begin
        logic [5:0] o;
        int cls;
        int abortAt;
        reset = 1'b1;
        op    = 6'b0;
        zero  = 1'b0;

        applyStimulus(1'b1, 6'b0, 1'b1, FETCH);
        applyStimulus(1'b1, 6'b0, 1'b0, FETCH);

        runInstr(OP_LW, 3, -1);
        runInstr(OP_LW, -1, -1);
        runInstr(OP_BEQ, -1, 1);
        runInstr(OP_BEQ, -1, 0);
        runInstr(OP_RTYPE, -1, -1);
        runInstr(6'b111111, -1, -1);
        runInstr(OP_SW, -1, -1);
        runInstr(OP_ADDI, -1, -1);
        runInstr(OP_J, -1, -1);

        for (int n = 0; n < 60; n++) begin
            cls = int'($urandom_range(0, 6));
            case (cls)
                0: o = OP_LW;
                1: o = OP_SW;
                2: o = OP_RTYPE;
                3: o = OP_BEQ;
                4: o = OP_ADDI;
                5: o = OP_J;
                default: begin
                    o = 6'($urandom);
                    while (knownOp(o)) o = 6'($urandom);
                end
            endcase
            abortAt = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
            runInstr(o, abortAt, -1);
        end

        applyStimulus(1'b0, 6'b111111, 1'b0, FETCH);
        repeat (3) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: actual=%0d pending required=0", expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
